test_pattern_source: RTL
========================

TEST_PATTERN_SOURCE -- requirements
Module: test_pattern_source

Interface
REQ-001 SHALL have parameters: DIS_RES_X, 320, pixels per row; DIS_RES_Y, 240, rows per frame; NUM_BANDS, 5, colour bands (1..8); LATENCY, 1, accept-to-ready cycles (1..4); CHECK_LOG2, 4, checker square size log2.
REQ-002 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-low reset; mem_req in 1 byte request pulse; mem_addr in 32 byte address; mode in 2 pattern select; mem_ready out 1 data-valid pulse; mem_out out 8 pixel byte; busy out 1 request pending; err out 2 sticky errors.

Function
REQ-003 SHALL serve a 2-byte RGB565 pixel per pair of addresses: even address = bits[15:8], odd address = bits[7:0].
REQ-004 SHALL accept mem_req only when busy=0; accept raises busy next cycle.
REQ-005 SHALL pulse mem_ready high for exactly one cycle LATENCY cycles after the accept cycle, with busy low that same cycle.
REQ-006 SHALL present mem_out valid in the mem_ready cycle and hold it until the next mem_ready.
REQ-007 SHALL ignore mem_req while busy=1 and set err[1] (overrun).
REQ-008 SHALL track pixel position with internal x (0..DIS_RES_X-1) and y (0..DIS_RES_Y-1) counters, not by dividing the address.
REQ-009 SHALL, on an accepted request with mem_addr=0, set x=0, y=0, band=0, and latch mode for the whole frame.
REQ-010 SHALL expect each accepted address to equal the previous accepted address+1, or 0; any other address sets err[0] (sequence) and is served from the current counters.
REQ-011 SHALL advance x after an odd-address byte; x wrap -> x=0, y+1; y wrap -> y=0.
REQ-012 SHALL use palette index 0..7 = RED F800, GREEN 07E0, BLUE 001F, YELLOW FFE0, CYAN 07FF, MAGENTA F81F, WHITE FFFF, BLACK 0000.
REQ-013 SHALL select the colour index by latched mode:
- 0 solid: index 0
- 1 horizontal bands: band from y
- 2 vertical bands: band from x
- 3 checker: x[CHECK_LOG2] XOR y[CHECK_LOG2] (0 -> WHITE, 1 -> BLACK)
REQ-014 SHALL set band height = DIS_RES_Y/NUM_BANDS rows (width = DIS_RES_X/NUM_BANDS for mode 2), using boundary counters, not division; the last band absorbs the remainder.
REQ-015 SHALL restart the band counter at each new row in mode 2 and at frame start in mode 1.
REQ-016 SHALL assert busy while a request is in flight; mem_req with mem_addr=0 while busy is an overrun and does not resync.

Reset
REQ-017 SHALL, while reset=0, asynchronously force mem_ready=0, mem_out=0x00, busy=0, err=00, x=y=band=0, latched mode=0, animation offset=0.
REQ-018 SHALL discard any in-flight request on reset; no mem_ready follows reset release without a new accept.
REQ-019 SHALL clear err only via reset.

Configuration
REQ-020 SHALL, with PATTERN_ANIM_EN defined, hold a 3-bit offset incremented on each accepted mem_addr=0 request after the first since reset, and output colour index (band+offset) mod 8 in modes 1 and 2.
REQ-021 SHALL, without PATTERN_ANIM_EN, use offset 0 permanently; frames are identical.

Verification
REQ-022 Mode 1, defaults, addr 0 then 1 -> mem_out 0xF8 then 0x00, each mem_ready exactly 1 cycle after its accept.
REQ-023 Mode 1, sequential addrs 0..30721 -> addr 30719 gives 0x00 (RED), addrs 30720/30721 give 0x07/0xE0 (GREEN, row 48); err=00.
REQ-024 Mode 3, sequential addrs 0..33 -> pixels 0..15 WHITE (0xFF,0xFF), pixel 16 (addrs 32/33) BLACK (0x00,0x00).
REQ-025 LATENCY=3, mem_req repeated 1 cycle after accept -> single mem_ready 3 cycles after accept, err[1]=1; addr 5 after 0 -> err[0]=1.
REQ-026 Reset=0 asserted mid-request with LATENCY=3 -> mem_ready never pulses, busy=0, err=00; with PATTERN_ANIM_EN, mode 1, second frame addr 0 -> 0x07 (GREEN).

Source files
------------

// File: rtl/test_pattern_source_if.sv
// ---------------------------------------------------------------------------------------------
// test_pattern_source_if
//   Byte-request bus between a pixel consumer (master) and the test pattern source (slave).
//   mem_req   : consumer -> source, one-cycle byte request
//   mem_addr  : consumer -> source, byte address of the request
//   mode      : consumer -> source, pattern select (latched by the source at address 0)
//   mem_ready : source -> consumer, one-cycle data-valid pulse
//   mem_out   : source -> consumer, pixel byte, held until the next mem_ready
//   busy      : source -> consumer, a request is in flight
//   err       : source -> consumer, sticky errors {overrun, sequence}
// ---------------------------------------------------------------------------------------------
interface test_pattern_source_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [1:0]  mode;
   logic        mem_ready;
   logic [7:0]  mem_out;
   logic        busy;
   logic [1:0]  err;

   modport master (
      output mem_req, mem_addr, mode,
      input  mem_ready, mem_out, busy, err
   );

   modport slave (
      input  mem_req, mem_addr, mode,
      output mem_ready, mem_out, busy, err
   );
endinterface

// File: rtl/test_pattern_source.sv
// ---------------------------------------------------------------------------------------------
// test_pattern_source
//   Serves RGB565 test-pattern pixels one byte per request. Even addresses return the high
//   byte, odd addresses the low byte; the pixel position comes from internal x/y counters
//   that advance after every odd byte and restart on a request for address 0.
//   Patterns: 0 solid red, 1 horizontal bands, 2 vertical bands, 3 checkerboard.
//
//   Ports
//     clk   : system clock
//     reset : asynchronous active-low reset
//     bus   : test_pattern_source_if.slave (mem_req, mem_addr, mode, mem_ready, mem_out,
//             busy, err)
//
//   Optional feature macro: PATTERN_ANIM_EN -- when defined, the band colours rotate by one
//   palette entry for every new frame after the first since reset.
// ---------------------------------------------------------------------------------------------
module test_pattern_source #(
   parameter int unsigned DIS_RES_X  = 320,
   parameter int unsigned DIS_RES_Y  = 240,
   parameter int unsigned NUM_BANDS  = 5,
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned CHECK_LOG2 = 4
) (
   input logic                  clk,
   input logic                  reset,
   test_pattern_source_if.slave bus
);

   localparam int unsigned XW     = (DIS_RES_X > 1) ? $clog2(DIS_RES_X) : 1;
   localparam int unsigned YW     = (DIS_RES_Y > 1) ? $clog2(DIS_RES_Y) : 1;
   localparam int unsigned CW     = (XW > YW) ? XW : YW;
   // Band sizes are elaboration-time constants; the datapath only counts up to them.
   localparam int unsigned BAND_W = (DIS_RES_X / NUM_BANDS > 0) ? DIS_RES_X / NUM_BANDS : 1;
   localparam int unsigned BAND_H = (DIS_RES_Y / NUM_BANDS > 0) ? DIS_RES_Y / NUM_BANDS : 1;

   localparam logic [XW-1:0] X_LAST    = XW'(DIS_RES_X - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(DIS_RES_Y - 1);
   localparam logic [CW-1:0] BW_LAST   = CW'(BAND_W - 1);
   localparam logic [CW-1:0] BH_LAST   = CW'(BAND_H - 1);
   localparam logic [2:0]    BAND_LAST = 3'(NUM_BANDS - 1);
   localparam logic [XW-1:0] X_CHK     = XW'(1) << CHECK_LOG2;
   localparam logic [YW-1:0] Y_CHK     = YW'(1) << CHECK_LOG2;

   // Registered state
   logic          ready_q;
   logic [7:0]    out_q;
   logic          busy_q;
   logic [1:0]    err_q;
   logic [1:0]    cnt_q;
   logic [7:0]    hold_q;
   logic [31:0]   prev_addr_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [2:0]    band_q;
   logic [CW-1:0] bcnt_q;
   logic [1:0]    mode_q;

   // Request decode
   logic accept;
   logic resync;
   logic seq_ok;

   // Pixel position the current request is served from
   logic [XW-1:0] eff_x;
   logic [YW-1:0] eff_y;
   logic [2:0]    eff_band;
   logic [CW-1:0] eff_bcnt;
   logic [1:0]    eff_mode;
   logic [2:0]    eff_offset;

   // Pixel data and next position
   logic [2:0]    colour_idx;
   logic [15:0]   pixel;
   logic [7:0]    serve_byte;
   logic          x_wrap;
   logic          y_wrap;
   logic [XW-1:0] x_d;
   logic [YW-1:0] y_d;
   logic [2:0]    band_d;
   logic [CW-1:0] bcnt_d;

   assign accept = bus.mem_req && !busy_q;
   assign resync = accept && (bus.mem_addr == 32'd0);
   // prev_addr_q resets to all ones so the first request after reset is expected at 0.
   assign seq_ok = (bus.mem_addr == prev_addr_q + 32'd1) || (bus.mem_addr == 32'd0);

   assign bus.mem_ready = ready_q;
   assign bus.mem_out   = out_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

   function automatic logic [15:0] palette(input logic [2:0] idx);
      logic [15:0] c;
      unique case (idx)
         3'd0:    c = 16'hF800;  // red
         3'd1:    c = 16'h07E0;  // green
         3'd2:    c = 16'h001F;  // blue
         3'd3:    c = 16'hFFE0;  // yellow
         3'd4:    c = 16'h07FF;  // cyan
         3'd5:    c = 16'hF81F;  // magenta
         3'd6:    c = 16'hFFFF;  // white
         default: c = 16'h0000;  // black
      endcase
      return c;
   endfunction

`ifdef PATTERN_ANIM_EN
   logic [2:0] offset_q;
   logic       started_q;

   // The first frame start after reset keeps offset 0; each later one rotates by one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         offset_q  <= 3'd0;
         started_q <= 1'b0;
      end else if (resync) begin
         if (started_q) begin
            offset_q <= offset_q + 3'd1;
         end
         started_q <= 1'b1;
      end
   end

   // The frame-start pixel already uses the rotated offset.
   assign eff_offset = (resync && started_q) ? offset_q + 3'd1 : offset_q;
`else
   assign eff_offset = 3'd0;
`endif

   // A request for address 0 is served from the restarted position with the new mode.
   always_comb begin
      eff_x    = x_q;
      eff_y    = y_q;
      eff_band = band_q;
      eff_bcnt = bcnt_q;
      eff_mode = mode_q;
      if (resync) begin
         eff_x    = '0;
         eff_y    = '0;
         eff_band = '0;
         eff_bcnt = '0;
         eff_mode = bus.mode;
      end
   end

   always_comb begin
      unique case (eff_mode)
         2'd0:       colour_idx = 3'd0;
         2'd1, 2'd2: colour_idx = eff_band + eff_offset;
         default:    colour_idx = ((|(eff_x & X_CHK)) ^ (|(eff_y & Y_CHK))) ? 3'd7 : 3'd6;
      endcase
      pixel      = palette(colour_idx);
      serve_byte = bus.mem_addr[0] ? pixel[7:0] : pixel[15:8];
   end

   // Position advance after an odd byte. Band counters only move in the banded modes;
   // the last band never advances so it absorbs the remainder of the row or frame.
   always_comb begin
      x_wrap = (eff_x == X_LAST);
      y_wrap = (eff_y == Y_LAST);
      x_d    = eff_x;
      y_d    = eff_y;
      band_d = eff_band;
      bcnt_d = eff_bcnt;
      if (bus.mem_addr[0]) begin
         x_d = x_wrap ? '0 : eff_x + 1'b1;
         if (x_wrap) begin
            y_d = y_wrap ? '0 : eff_y + 1'b1;
         end
         if (eff_mode == 2'd2) begin
            if (x_wrap) begin
               band_d = '0;
               bcnt_d = '0;
            end else if (eff_band != BAND_LAST) begin
               if (eff_bcnt == BW_LAST) begin
                  band_d = eff_band + 3'd1;
                  bcnt_d = '0;
               end else begin
                  bcnt_d = eff_bcnt + 1'b1;
               end
            end
         end else if ((eff_mode == 2'd1) && x_wrap) begin
            if (y_wrap) begin
               band_d = '0;
               bcnt_d = '0;
            end else if (eff_band != BAND_LAST) begin
               if (eff_bcnt == BH_LAST) begin
                  band_d = eff_band + 3'd1;
                  bcnt_d = '0;
               end else begin
                  bcnt_d = eff_bcnt + 1'b1;
               end
            end
         end
      end
   end

   // With LATENCY=1 the byte is returned in the cycle right after the accept, so busy never
   // becomes visible and back-to-back requests are accepted every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q     <= 1'b0;
         out_q       <= 8'h00;
         busy_q      <= 1'b0;
         err_q       <= 2'b00;
         cnt_q       <= 2'd0;
         hold_q      <= 8'h00;
         prev_addr_q <= '1;
         x_q         <= '0;
         y_q         <= '0;
         band_q      <= '0;
         bcnt_q      <= '0;
         mode_q      <= 2'd0;
      end else begin
         ready_q <= 1'b0;
         if (bus.mem_req && busy_q) begin
            err_q[1] <= 1'b1;
         end
         if (accept) begin
            if (!seq_ok) begin
               err_q[0] <= 1'b1;
            end
            prev_addr_q <= bus.mem_addr;
            x_q         <= x_d;
            y_q         <= y_d;
            band_q      <= band_d;
            bcnt_q      <= bcnt_d;
            if (resync) begin
               mode_q <= bus.mode;
            end
            if (LATENCY <= 1) begin
               ready_q <= 1'b1;
               out_q   <= serve_byte;
            end else begin
               busy_q <= 1'b1;
               cnt_q  <= 2'(LATENCY - 1);
               hold_q <= serve_byte;
            end
         end else if (busy_q) begin
            if (cnt_q == 2'd1) begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               out_q   <= hold_q;
            end else begin
               cnt_q <= cnt_q - 2'd1;
            end
         end
      end
   end

endmodule
